// File: rtl/jarch_stack_pkg.sv
// Constants and operation encoding shared by the hardware stack and the register file.
package jarch_stack_pkg;

    localparam logic [7:0] STACK_TOP_REG    = 8'h20;
    localparam logic [7:0] STACK_AMOUNT_REG = 8'h21;

    localparam int STACK_DEPTH_DEF    = 64;
    localparam int STACK_DATA_W_DEF   = 32;
    localparam int STACK_AMOUNT_W_DEF = 16;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PUSH    = 2'd1,
        POP     = 2'd2,
        REPLACE = 2'd3
    } stack_op;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one write port on the falling edge, combinational top read and optional peek read.
import jarch_stack_pkg::*;

module stack_mem #(
    parameter int DEPTH  = STACK_DEPTH_DEF,
    parameter int DATA_W = STACK_DATA_W_DEF
) (
    input  logic                       clock,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
`ifdef HW_STACK_PEEK_EN
    input  logic [$clog2(DEPTH)-1:0]   peek_addr,
    output logic [DATA_W-1:0]          peek_data,
`endif
    input  logic [$clog2(DEPTH)-1:0]   top_addr,
    output logic [DATA_W-1:0]          top_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the pointer alone defines validity.
    always_ff @(negedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign top_data = mem[top_addr];

`ifdef HW_STACK_PEEK_EN
    assign peek_data = mem[peek_addr];
`endif

endmodule

// File: rtl/hardware_stack.sv
// LIFO behind the register-file stack port; updates on the falling edge, top visible with zero latency.
// No back-pressure: every push/pop completes in one cycle. HW_STACK_PEEK_EN adds a registered peek port.
import jarch_stack_pkg::*;

module hardware_stack #(
    parameter int DEPTH    = STACK_DEPTH_DEF,
    parameter int DATA_W   = STACK_DATA_W_DEF,
    parameter int AMOUNT_W = STACK_AMOUNT_W_DEF
) (
    input  logic                clock,
    input  logic                init,
    input  logic                STACK_push_flag,
    input  logic [DATA_W-1:0]   STACK_push_value,
    input  logic                STACK_pop_flag,
    input  logic                STACK_clear_err,
`ifdef HW_STACK_PEEK_EN
    input  logic [AMOUNT_W-1:0] STACK_peek_index,
    output logic [DATA_W-1:0]   STACK_peek_data,
`endif
    output logic [DATA_W-1:0]   STACK_TOP,
    output logic [AMOUNT_W-1:0] STACK_AMOUNT,
    output logic                STACK_full,
    output logic                STACK_empty,
    output logic                STACK_overflow,
    output logic                STACK_underflow
);

    localparam int SP_W = AMOUNT_W + 1;
    localparam int AW   = $clog2(DEPTH);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    logic [SP_W-1:0]   sp;
    logic              is_empty;
    logic              is_full;
    stack_op           op;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     top_addr;
    logic [DATA_W-1:0] top_data;

    assign is_empty = (sp == '0);
    assign is_full  = (sp == SP_FULL);

    // Push+pop on an empty stack degenerates to a plain push.
    always_comb begin
        op = NONE;
        unique case ({STACK_push_flag, STACK_pop_flag})
            2'b10:   op = PUSH;
            2'b01:   op = POP;
            2'b11:   op = is_empty ? PUSH : REPLACE;
            default: op = NONE;
        endcase
    end

    assign top_addr = AW'(sp - SP_W'(1));
    assign wr_en    = ((op == PUSH) && !is_full) || (op == REPLACE);
    assign wr_addr  = (op == PUSH) ? AW'(sp) : top_addr;

    always_ff @(negedge clock or negedge init) begin
        if (!init) begin
            sp              <= '0;
            STACK_overflow  <= 1'b0;
            STACK_underflow <= 1'b0;
        end else begin
            case (op)
                PUSH:    if (!is_full)  sp <= sp + SP_W'(1);
                POP:     if (!is_empty) sp <= sp - SP_W'(1);
                default: ;
            endcase
            // A fresh error on the clearing edge keeps its flag set.
            STACK_overflow  <= (STACK_overflow  & ~STACK_clear_err) | ((op == PUSH) && is_full);
            STACK_underflow <= (STACK_underflow & ~STACK_clear_err) | ((op == POP)  && is_empty);
        end
    end

`ifdef HW_STACK_PEEK_EN
    logic [SP_W-1:0]   peek_ext;
    logic              peek_hit;
    logic [AW-1:0]     peek_addr;
    logic [DATA_W-1:0] peek_rd;

    assign peek_ext  = {1'b0, STACK_peek_index};
    assign peek_hit  = (peek_ext < sp);
    assign peek_addr = AW'(sp - SP_W'(1) - peek_ext);

    always_ff @(negedge clock or negedge init) begin
        if (!init) begin
            STACK_peek_data <= '0;
        end else begin
            STACK_peek_data <= peek_hit ? peek_rd : '0;
        end
    end
`endif

    stack_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clock     (clock),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (STACK_push_value),
`ifdef HW_STACK_PEEK_EN
        .peek_addr (peek_addr),
        .peek_data (peek_rd),
`endif
        .top_addr  (top_addr),
        .top_data  (top_data)
    );

    assign STACK_TOP    = is_empty ? '0 : top_data;
    assign STACK_AMOUNT = sp[AMOUNT_W-1:0];
    assign STACK_full   = is_full;
    assign STACK_empty  = is_empty;

endmodule

// File: tb/tb_hardware_stack.sv
// Directed-vector bench for hardware_stack with DEPTH = 4; peek checks only when HW_STACK_PEEK_EN is set.
module tb_hardware_stack;

    localparam int DEPTH    = 4;
    localparam int DATA_W   = 32;
    localparam int AMOUNT_W = 16;

    logic                clock;
    logic                init;
    logic                push_flag;
    logic [DATA_W-1:0]   push_value;
    logic                pop_flag;
    logic                clear_err;
    logic [DATA_W-1:0]   top;
    logic [AMOUNT_W-1:0] amount;
    logic                full;
    logic                empty;
    logic                overflow;
    logic                underflow;
`ifdef HW_STACK_PEEK_EN
    logic [AMOUNT_W-1:0] peek_index;
    logic [DATA_W-1:0]   peek_data;
`endif

    int vectors;
    int miscompares;

    hardware_stack #(
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .AMOUNT_W (AMOUNT_W)
    ) dut (
        .clock            (clock),
        .init             (init),
        .STACK_push_flag  (push_flag),
        .STACK_push_value (push_value),
        .STACK_pop_flag   (pop_flag),
        .STACK_clear_err  (clear_err),
`ifdef HW_STACK_PEEK_EN
        .STACK_peek_index (peek_index),
        .STACK_peek_data  (peek_data),
`endif
        .STACK_TOP        (top),
        .STACK_AMOUNT     (amount),
        .STACK_full       (full),
        .STACK_empty      (empty),
        .STACK_overflow   (overflow),
        .STACK_underflow  (underflow)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one operation from the rising edge, let the falling edge apply it, then idle the inputs.
    task automatic step(input logic ps, input logic pp, input logic [31:0] v, input logic cl);
        @(posedge clock);
        #1;
        push_flag  = ps;
        pop_flag   = pp;
        push_value = v;
        clear_err  = cl;
        @(negedge clock);
        #1;
        push_flag  = 1'b0;
        pop_flag   = 1'b0;
        push_value = '0;
        clear_err  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 init = 1'b0;
        #2 init = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        init        = 1'b0;
        push_flag   = 1'b0;
        pop_flag    = 1'b0;
        push_value  = '0;
        clear_err   = 1'b0;
`ifdef HW_STACK_PEEK_EN
        peek_index  = '0;
`endif
        #12;
        check("rst_amount", 32'(amount), 32'd0);
        check("rst_top", top, 32'h0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        init = 1'b1;

        step(1'b1, 1'b0, 32'h11, 1'b0);
        step(1'b1, 1'b0, 32'h22, 1'b0);
        step(1'b1, 1'b0, 32'h33, 1'b0);
        check("push3_amount", 32'(amount), 32'd3);
        check("push3_top", top, 32'h33);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check("pop_amount", 32'(amount), 32'd2);
        check("pop_top", top, 32'h22);

        step(1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_unf", 32'(underflow), 32'd0);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check("unf_amount", 32'(amount), 32'd0);
        check("unf_top", top, 32'h0);
        check("unf_flag", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("unf_clear", 32'(underflow), 32'd0);

        step(1'b1, 1'b0, 32'h1, 1'b0);
        step(1'b1, 1'b0, 32'h2, 1'b0);
        step(1'b1, 1'b0, 32'h3, 1'b0);
        step(1'b1, 1'b0, 32'h4, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_ovf", 32'(overflow), 32'd0);
        step(1'b1, 1'b0, 32'h5, 1'b0);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_amount", 32'(amount), 32'd4);
        check("ovf_top", top, 32'h4);
        check("ovf_flag", 32'(overflow), 32'd1);
        step(1'b1, 1'b1, 32'hAA, 1'b0);
        check("repl_full_top", top, 32'hAA);
        check("repl_full_amount", 32'(amount), 32'd4);
        check("repl_full_ovf", 32'(overflow), 32'd1);
        step(1'b1, 1'b0, 32'h6, 1'b1);
        check("clear_vs_err_ovf", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("ovf_clear", 32'(overflow), 32'd0);

        step(1'b0, 1'b1, 32'h0, 1'b0);
        check("pop_from_full_top", top, 32'h3);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        check("empty_again", 32'(empty), 32'd1);
        step(1'b1, 1'b1, 32'h55, 1'b0);
        check("pp_empty_amount", 32'(amount), 32'd1);
        check("pp_empty_top", top, 32'h55);
        check("pp_empty_unf", 32'(underflow), 32'd0);
        step(1'b1, 1'b1, 32'h66, 1'b0);
        check("pp_one_amount", 32'(amount), 32'd1);
        check("pp_one_top", top, 32'h66);

        step(1'b1, 1'b0, 32'h67, 1'b0);
        step(1'b1, 1'b0, 32'h68, 1'b0);
        check("pre_rst_amount", 32'(amount), 32'd3);
        @(posedge clock);
        #2 init = 1'b0;
        #1;
        check("async_rst_amount", 32'(amount), 32'd0);
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_top", top, 32'h0);
        @(posedge clock);
        #1 init = 1'b1;
        step(1'b1, 1'b0, 32'h77, 1'b0);
        check("post_rst_top", top, 32'h77);
        check("post_rst_amount", 32'(amount), 32'd1);

`ifdef HW_STACK_PEEK_EN
        do_reset();
        step(1'b1, 1'b0, 32'hA, 1'b0);
        step(1'b1, 1'b0, 32'hB, 1'b0);
        step(1'b1, 1'b0, 32'hC, 1'b0);
        @(posedge clock);
        #1 peek_index = 16'd2;
        @(negedge clock);
        #1;
        check("peek_idx2", peek_data, 32'hA);
        @(posedge clock);
        #1 peek_index = 16'd3;
        @(negedge clock);
        #1;
        check("peek_idx3", peek_data, 32'h0);
        @(posedge clock);
        #1 peek_index = 16'd0;
        @(negedge clock);
        #1;
        check("peek_idx0", peek_data, 32'hC);
`else
        do_reset();
        check("final_rst_amount", 32'(amount), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
